zeroriscy_instr_bus_arbiter: RTL and testbench

Two-master arbiter that shares the single instruction-memory port (req/addr/gnt/rvalid/rdata, in-order responses) between the core fetch path (prefetch buffer) and a secondary fetcher (debug unit / boot loader). It sits between those masters and the memory port. It locks the selected master until its request is granted, and it records the owner of every granted transaction in an in-order ID FIFO. Each response is routed back to its owner using that FIFO.

---
 rtl/zeroriscy_instr_arb_pkg.sv | 13 +
 rtl/zeroriscy_instr_arb_id_fifo.sv | 59 +++++
 rtl/zeroriscy_instr_bus_arbiter.sv | 129 ++++++++++++
 tb/tb_zeroriscy_instr_bus_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/zeroriscy_instr_arb_pkg.sv
// Shared types for the instruction-bus arbiter.
// Master IDs and arbitration FSM state encoding.
package zeroriscy_instr_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_t;

  localparam logic ARB_ID_M0 = 1'b0;
  localparam logic ARB_ID_M1 = 1'b1;

endpackage

// File: rtl/zeroriscy_instr_arb_id_fifo.sv
// In-order owner FIFO for granted-but-unanswered fetches.
// One bit per entry: the master ID that owns the transaction.
module zeroriscy_instr_arb_id_fifo #(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW = $clog2(DEPTH + 1),
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic          i_id,
  input  logic          i_pop,
  output logic          o_head,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  logic [DEPTH-1:0] r_mem;
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PW-1:0] f_nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign o_count = r_count;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mem   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_id;
        r_wptr        <= f_nxt(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= f_nxt(r_rptr);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/zeroriscy_instr_bus_arbiter.sv
// Two-master instruction-bus arbiter with lock-until-grant and in-order routing.
// Define ZERORISCY_INSTR_ARB_RR_EN for round-robin; default is fixed m0 > m1.
module zeroriscy_instr_bus_arbiter
  import zeroriscy_instr_arb_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req_i,
  input  logic [31:0] m0_addr_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  input  logic        m1_req_i,
  input  logic [31:0] m1_addr_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  output logic        busy_o,
  output logic        err_o
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

  arb_state_t    r_state;
  logic          r_owner;
  logic          r_err;
`ifdef ZERORISCY_INSTR_ARB_RR_EN
  logic          r_last;
`endif
  logic          w_sel;
  logic          w_req;
  logic          w_push;
  logic          w_pop;
  logic          w_head;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;

  always_comb begin
    w_req = m0_req_i | m1_req_i;
`ifdef ZERORISCY_INSTR_ARB_RR_EN
    if (m0_req_i && m1_req_i) begin
      w_sel = (r_last == ARB_ID_M1) ? ARB_ID_M0 : ARB_ID_M1;
    end else begin
      w_sel = m0_req_i ? ARB_ID_M0 : ARB_ID_M1;
    end
`else
    w_sel = m0_req_i ? ARB_ID_M0 : ARB_ID_M1;
`endif
    // A locked owner holds the port; the other master is ignored.
    if (r_state == ARB_LOCKED) begin
      w_sel = r_owner;
      w_req = (r_owner == ARB_ID_M1) ? m1_req_i : m0_req_i;
    end
  end

  assign instr_req_o  = w_req & ~w_full;
  assign instr_addr_o = (w_sel == ARB_ID_M1) ? m1_addr_i : m0_addr_i;
  assign w_push       = instr_gnt_i & instr_req_o;
  assign w_pop        = instr_rvalid_i & ~w_empty;

  assign m0_gnt_o    = w_push & (w_sel == ARB_ID_M0);
  assign m1_gnt_o    = w_push & (w_sel == ARB_ID_M1);
  assign m0_rvalid_o = w_pop & (w_head == ARB_ID_M0);
  assign m1_rvalid_o = w_pop & (w_head == ARB_ID_M1);
  assign m0_rdata_o  = instr_rdata_i;
  assign m1_rdata_o  = instr_rdata_i;
  assign busy_o      = (w_count != '0) | instr_req_o;
  assign err_o       = r_err;

  zeroriscy_instr_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_id    (w_sel),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ARB_IDLE;
      r_owner <= ARB_ID_M0;
      r_err   <= 1'b0;
`ifdef ZERORISCY_INSTR_ARB_RR_EN
      r_last  <= ARB_ID_M1;
`endif
    end else begin
      if (instr_rvalid_i && w_empty) begin
        r_err <= 1'b1;
      end
`ifdef ZERORISCY_INSTR_ARB_RR_EN
      if (w_push) begin
        r_last <= w_sel;
      end
`endif
      // A full FIFO freezes the FSM, keeping any lock in place.
      if (!w_full) begin
        unique case (r_state)
          ARB_IDLE: begin
            if (w_req && !instr_gnt_i) begin
              r_state <= ARB_LOCKED;
              r_owner <= w_sel;
            end
          end
          ARB_LOCKED: begin
            if (instr_gnt_i || !w_req) begin
              r_state <= ARB_IDLE;
            end
          end
          default: r_state <= ARB_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_zeroriscy_instr_bus_arbiter.sv
// Scoreboard bench for the instruction-bus arbiter.
// Checks either build, selected by ZERORISCY_INSTR_ARB_RR_EN.
module tb_zeroriscy_instr_bus_arbiter;

  localparam int unsigned MAXO = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req_i, m1_req_i;
  logic [31:0] m0_addr_i, m1_addr_i;
  logic        m0_gnt_o, m1_gnt_o;
  logic        m0_rvalid_o, m1_rvalid_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i, instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        busy_o, err_o;

  always #5 clk = ~clk;

  zeroriscy_instr_bus_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .m0_req_i       (m0_req_i),
    .m0_addr_i      (m0_addr_i),
    .m0_gnt_o       (m0_gnt_o),
    .m0_rvalid_o    (m0_rvalid_o),
    .m0_rdata_o     (m0_rdata_o),
    .m1_req_i       (m1_req_i),
    .m1_addr_i      (m1_addr_i),
    .m1_gnt_o       (m1_gnt_o),
    .m1_rvalid_o    (m1_rvalid_o),
    .m1_rdata_o     (m1_rdata_o),
    .instr_req_o    (instr_req_o),
    .instr_addr_o   (instr_addr_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .busy_o         (busy_o),
    .err_o          (err_o)
  );

  typedef struct packed {
    logic        id;
    logic [31:0] data;
  } exp_t;

  exp_t        expq[$];
  logic [31:0] memq[$];
  int n_chk = 0;
  int n_fail = 0;
  int n_exp_resp = 0;
  int n_got_resp = 0;

  // Reference view: outstanding count, lock owner, last grantee, error flag.
  int m_cnt;
  bit m_lock, m_own, m_last, m_err;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    if (a == 32'h80) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    m0_req_i = 0; m1_req_i = 0;
    m0_addr_i = 0; m1_addr_i = 0;
    instr_gnt_i = 0; instr_rvalid_i = 0;
    instr_rdata_i = 0;
    @(posedge clk);
    #1;
    chk("rst_instr_req", instr_req_o, 0);
    chk("rst_gnt", {m0_gnt_o, m1_gnt_o}, 0);
    chk("rst_rvalid", {m0_rvalid_o, m1_rvalid_o}, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_o, 0);
    m_cnt = 0; m_lock = 0; m_own = 0; m_last = 1; m_err = 0;
    expq.delete();
    memq.delete();
    rst_n = 1'b1;
  endtask

  task automatic step(input bit r0, input bit r1,
                      input logic [31:0] a0, input logic [31:0] a1,
                      input bit g, input bit rv,
                      output bit g0, output bit g1);
    bit full, er, sel;
    logic [31:0] d;
    @(posedge clk);
    #1;
    m0_req_i = r0; m1_req_i = r1;
    m0_addr_i = a0; m1_addr_i = a1;
    instr_gnt_i = g;
    instr_rvalid_i = rv;
    if (rv && memq.size() > 0) instr_rdata_i = memq.pop_front();
    else instr_rdata_i = $urandom;
    full = (m_cnt == MAXO);
    sel = 0;
    er = 0;
    if (full) begin
      er = 0;
    end else if (m_lock) begin
      sel = m_own;
      er = m_own ? r1 : r0;
    end else begin
      er = r0 | r1;
`ifdef ZERORISCY_INSTR_ARB_RR_EN
      if (r0 && r1) sel = !m_last;
      else sel = !r0;
`else
      sel = !r0;
`endif
    end
    g0 = er && g && !sel;
    g1 = er && g && sel;
    #3;
    chk("instr_req", instr_req_o, er);
    if (er) chk("instr_addr", instr_addr_o, sel ? a1 : a0);
    chk("m0_gnt", m0_gnt_o, g0);
    chk("m1_gnt", m1_gnt_o, g1);
    chk("busy", busy_o, (m_cnt != 0) || er);
    chk("err", err_o, m_err);
    chk("m0_rdata", m0_rdata_o, instr_rdata_i);
    chk("m1_rdata", m1_rdata_o, instr_rdata_i);
    if (rv) begin
      if (m_cnt == 0) m_err = 1;
      else begin
        n_exp_resp++;
        m_cnt--;
      end
    end
    if (er && g) begin
      d = mdata(sel ? a1 : a0);
      memq.push_back(d);
      expq.push_back('{id: sel, data: d});
      m_cnt++;
      m_last = sel;
    end
    if (!full) begin
      if (m_lock) begin
        if (g || !er) m_lock = 0;
      end else if (er && !g) begin
        m_lock = 1;
        m_own = sel;
      end
    end
  endtask

  task automatic drain();
    bit g0, g1;
    while (memq.size() > 0) step(0, 0, 0, 0, 0, 1, g0, g1);
    step(0, 0, 0, 0, 0, 0, g0, g1);
  endtask

  // Response monitor: every delivered rvalid must match the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (m0_rvalid_o || m1_rvalid_o) begin
        n_got_resp++;
        chk("rvalid_onehot", {m0_rvalid_o, m1_rvalid_o} == 2'b11, 0);
        if (expq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL resp_unexpected: got rvalid %b%b expected none",
                   m1_rvalid_o, m0_rvalid_o);
        end else begin
          e = expq.pop_front();
          chk("resp_owner", m1_rvalid_o, e.id);
          chk("resp_data", m0_rdata_o, e.data);
        end
      end
    end
  end

  initial begin
    bit g0, g1;
    bit rq[2];
    logic [31:0] ad[2];
    rst_n = 1'b0;
    do_reset();

    // Single master with a two-cycle response.
    step(1, 0, 32'h80, 0, 1, 0, g0, g1);
    step(0, 0, 0, 0, 0, 0, g0, g1);
    step(0, 0, 0, 0, 0, 1, g0, g1);
    step(0, 0, 0, 0, 0, 0, g0, g1);

    // Both masters, memory grants and answers every cycle.
    for (int i = 0; i < 6; i++)
      step(1, 1, 32'h200 + i * 4, 32'h300 + i * 4, 1,
           memq.size() > 0, g0, g1);
    drain();

    // m1 locks the port while the grant is withheld.
    step(0, 1, 32'h40, 32'h100, 0, 0, g0, g1);
    step(1, 1, 32'h40, 32'h100, 0, 0, g0, g1);
    step(1, 1, 32'h40, 32'h100, 0, 0, g0, g1);
    step(1, 1, 32'h40, 32'h100, 1, 0, g0, g1);
    drain();

    // Fill the FIFO, then a request waits for a pop.
    step(1, 0, 32'h500, 0, 1, 0, g0, g1);
    step(1, 0, 32'h504, 0, 1, 0, g0, g1);
    step(1, 0, 32'h508, 0, 1, 0, g0, g1);
    step(1, 0, 32'h508, 0, 1, 1, g0, g1);
    step(1, 0, 32'h508, 0, 1, 0, g0, g1);
    drain();

    rq[0] = 0; rq[1] = 0; ad[0] = 0; ad[1] = 0;
    for (int i = 0; i < 3000; i++) begin
      for (int m = 0; m < 2; m++) begin
        if (!rq[m]) begin
          if ($urandom % 3 == 0) begin
            rq[m] = 1;
            ad[m] = $urandom;
          end
        end else if ($urandom % 50 == 0) begin
          rq[m] = 0;
        end
      end
      step(rq[0], rq[1], ad[0], ad[1], ($urandom % 3) != 0,
           (memq.size() > 0) && ($urandom % 2 == 0), g0, g1);
      if (g0) rq[0] = 0;
      if (g1) rq[1] = 0;
    end
    drain();

    // Spurious responses with nothing outstanding.
    step(0, 0, 0, 0, 0, 1, g0, g1);
    step(0, 0, 0, 0, 0, 0, g0, g1);
    step(0, 0, 0, 0, 0, 1, g0, g1);
    step(0, 0, 0, 0, 0, 0, g0, g1);
    do_reset();
    step(0, 0, 0, 0, 0, 0, g0, g1);

    #4;
    chk("resp_count", n_got_resp, n_exp_resp);
    chk("expq_empty", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
